// File: rtl/pixel_frame_sequencer_pkg.sv
// Shared definitions for the pixel frame sequencer.
//   seq_state_e       : frame controller state encoding
//   CNT_WIDTH_DEFAULT : default width of the beat counters and frame length
package pixel_frame_sequencer_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_ABORT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-register stream slice: an output register plus one skid register that
// catches a beat arriving while the output is stalled.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : drop the skid beat and any incoming beat; mark a stalled
//                       output beat as last
//   in_valid_i/...    : accepted input beat (valid already qualified by ready)
//   out_*             : registered output stream
//   skid_empty_next_o : skid register will be empty after this edge
module axis_skid_buffer #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 skid_empty_next_o
);

  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DataWidth-1:0] skid_data_q, skid_data_d;
  logic                 skid_last_q, skid_last_d;
  logic                 out_fire;

  assign out_fire = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (flush_i) begin
      skid_valid_d = 1'b0;
      if (out_fire) begin
        out_valid_d = 1'b0;
      end else if (out_valid_q) begin
        out_last_d = 1'b1;
      end
    end else if (!out_valid_q || out_fire) begin
      // Output slot frees up: the older skid beat goes first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = in_valid_i;
        skid_data_d  = in_data_i;
        skid_last_d  = in_last_i;
      end else begin
        out_valid_d = in_valid_i;
        if (in_valid_i) begin
          out_data_d = in_data_i;
          out_last_d = in_last_i;
        end
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
      skid_last_d  = in_last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign out_valid_o       = out_valid_q;
  assign out_data_o        = out_data_q;
  assign out_last_o        = out_last_q;
  assign skid_empty_next_o = ~skid_valid_d;

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame-level controller: admits cfg_frame_beats stream beats per start pulse,
// forwards them through a skid slice with m_axis_last on the final beat, and
// supports abort.
//   axi_clk, axi_reset   : clock, synchronous active-high reset
//   cfg_start/abort      : control pulses; cfg_frame_beats latched on start
//   status_*             : busy, done pulse, aborted flag, output beat count
//   s_axis_*             : upstream stream (ready registered)
//   m_axis_*             : downstream stream (all registered)
module pixel_frame_sequencer
  import pixel_frame_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  cfg_start,
  input  logic [CNT_WIDTH-1:0]  cfg_frame_beats,
  input  logic                  cfg_abort,
  output logic                  status_busy,
  output logic                  status_done,
  output logic                  status_aborted,
  output logic [CNT_WIDTH-1:0]  status_beat_count,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] frame_beats_q, frame_beats_d;
  logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic                 flush;
  logic                 in_fire, out_fire, in_last, skid_empty_next;

  assign in_fire  = s_axis_valid & ready_q;
  assign out_fire = m_axis_valid & m_axis_ready;
  // Order is preserved, so the input index identifies the final output beat.
  assign in_last  = (in_cnt_q == frame_beats_q - CntOne);

  always_comb begin
    state_d       = state_q;
    frame_beats_d = frame_beats_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    done_d        = 1'b0;
    aborted_d     = aborted_q;
    flush         = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (cfg_start && !cfg_abort) begin
          if (cfg_frame_beats == '0) begin
            done_d = 1'b1;
          end else begin
            state_d       = SEQ_RUN;
            frame_beats_d = cfg_frame_beats;
            in_cnt_d      = '0;
            out_cnt_d     = '0;
            aborted_d     = 1'b0;
          end
        end
      end
      SEQ_RUN: begin
        if (in_fire && !cfg_abort && (in_cnt_q < frame_beats_q)) begin
          in_cnt_d = in_cnt_q + CntOne;
        end
        if (out_fire && (out_cnt_q < frame_beats_q)) begin
          out_cnt_d = out_cnt_q + CntOne;
        end
        if (cfg_abort) begin
          flush     = 1'b1;
          aborted_d = 1'b1;
          // A beat still waiting at the output must finish its handshake.
          if (m_axis_valid && !m_axis_ready) begin
            state_d = SEQ_ABORT;
          end else begin
            state_d = SEQ_IDLE;
            done_d  = 1'b1;
          end
        end else if (out_fire && m_axis_last) begin
          state_d = SEQ_IDLE;
          done_d  = 1'b1;
        end
      end
      SEQ_ABORT: begin
        if (out_fire) begin
          if (out_cnt_q < frame_beats_q) begin
            out_cnt_d = out_cnt_q + CntOne;
          end
          state_d = SEQ_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign ready_d = (state_d == SEQ_RUN) && skid_empty_next && (in_cnt_d < frame_beats_d);

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q       <= SEQ_IDLE;
      frame_beats_q <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_beats_q <= frame_beats_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  axis_skid_buffer #(
    .DataWidth(DATA_WIDTH)
  ) u_skid (
    .clk_i            (axi_clk),
    .rst_i            (axi_reset),
    .flush_i          (flush),
    .in_valid_i       (in_fire),
    .in_data_i        (s_axis_data),
    .in_last_i        (in_last),
    .out_valid_o      (m_axis_valid),
    .out_data_o       (m_axis_data),
    .out_last_o       (m_axis_last),
    .out_ready_i      (m_axis_ready),
    .skid_empty_next_o(skid_empty_next)
  );

  assign s_axis_ready      = ready_q;
  assign status_busy       = (state_q != SEQ_IDLE);
  assign status_done       = done_q;
  assign status_aborted    = aborted_q;
  assign status_beat_count = out_cnt_q;

endmodule
